// File: rtl/tis_node_sequencer_pkg.sv
// ============================================================================
//  Module      : tis_node_sequencer_pkg
//  Description : Shared opcode, source, ALU and FSM encodings for the node.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tis_node_sequencer_pkg;

    // Field layout of a program word; rsvd bits are ignored by the decoder.
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] src;
        logic [1:0] rsvd;
        logic [7:0] imm;
    } instr_t;

    localparam logic [3:0] c_op_nop     = 4'h0;
    localparam logic [3:0] c_op_mov_acc = 4'h1;
    localparam logic [3:0] c_op_mov_out = 4'h2;
    localparam logic [3:0] c_op_add     = 4'h3;
    localparam logic [3:0] c_op_sub     = 4'h4;
    localparam logic [3:0] c_op_neg     = 4'h5;
    localparam logic [3:0] c_op_swp     = 4'h6;
    localparam logic [3:0] c_op_sav     = 4'h7;
    localparam logic [3:0] c_op_jmp     = 4'h8;
    localparam logic [3:0] c_op_jez     = 4'h9;
    localparam logic [3:0] c_op_jnz     = 4'hA;
    localparam logic [3:0] c_op_jgz     = 4'hB;
    localparam logic [3:0] c_op_jlz     = 4'hC;

    localparam logic [1:0] c_src_imm = 2'b00;
    localparam logic [1:0] c_src_acc = 2'b01;
    localparam logic [1:0] c_src_in  = 2'b10;
    localparam logic [1:0] c_src_nil = 2'b11;

    localparam logic [1:0] c_alu_pass = 2'b00;
    localparam logic [1:0] c_alu_add  = 2'b01;
    localparam logic [1:0] c_alu_sub  = 2'b10;
    localparam logic [1:0] c_alu_neg  = 2'b11;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_run      = 2'd1;
    localparam logic [1:0] c_st_wait_out = 2'd2;

    function automatic logic [1:0] alu_code(input logic [3:0] op);
        case (op)
            c_op_add: alu_code = c_alu_add;
            c_op_sub: alu_code = c_alu_sub;
            c_op_neg: alu_code = c_alu_neg;
            default:  alu_code = c_alu_pass;
        endcase
    endfunction

    // Only the MOV and arithmetic ops consume their source operand.
    function automatic logic reads_src(input logic [3:0] op);
        reads_src = (op == c_op_mov_acc) || (op == c_op_mov_out) ||
                    (op == c_op_add)     || (op == c_op_sub);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tis_node_sequencer_if.sv
// ============================================================================
//  Module      : tis_node_sequencer_if
//  Description : Neighbour input/output valid-ready links of one node.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tis_node_sequencer_if #(
    parameter int N = 8
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/tis_node_sequencer_alu.sv
// ============================================================================
//  Module      : tis_node_sequencer_alu
//  Description : Wrapping N-bit ALU: pass, ADD, SUB (a - b), NEG.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tis_node_sequencer_alu
    import tis_node_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic [1:0]   i_code,
    input  wire logic [N-1:0] i_a,
    input  wire logic [N-1:0] i_b,
    output logic      [N-1:0] o_res
);

    always_comb begin
        case (i_code)
            c_alu_add: o_res = i_a + i_b;
            c_alu_sub: o_res = i_a - i_b;
            c_alu_neg: o_res = '0 - i_a;
            default:   o_res = i_b;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tis_node_sequencer.sv
// ============================================================================
//  Module      : tis_node_sequencer
//  Description : Single TIS-100 node: program store, fetch/execute FSM,
//                ACC/BAK sequencing and neighbour valid-ready ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tis_node_sequencer
    import tis_node_sequencer_pkg::*;
#(
    parameter int N          = 8,
    parameter int PROG_DEPTH = 16,
    localparam int AW        = $clog2(PROG_DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          prog_we,
    input  wire logic [AW-1:0] prog_addr,
    input  wire logic [15:0]   prog_data,
    input  wire logic          run,
    tis_node_sequencer_if.slave lnk,
    output logic      [N-1:0]  acc_o,
    output logic      [AW-1:0] pc_o,
    output logic               stalled
);

    localparam logic [AW-1:0] c_pc_one = AW'(1);

    logic [15:0]   r_mem [PROG_DEPTH];
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_bak;
    logic [N-1:0]  r_out_data;
    logic          r_out_valid;

    instr_t        w_instr;
    logic [N-1:0]  w_imm_ext;
    logic [N-1:0]  w_src_val;
    logic [N-1:0]  w_alu_res;
    logic          w_uses_in;
    logic          w_in_blocked;
    logic          w_out_accept;
    logic          w_take_jump;
    logic          w_exec;
    logic          w_in_ready;
    logic          w_stalled;
    logic          w_unused_bits;

    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign w_instr       = instr_t'(r_mem[r_pc]);
    assign w_unused_bits = ^{w_instr.rsvd, w_instr.imm};

    generate
        if (N > 8) begin : g_imm_sext
            assign w_imm_ext = {{(N-8){w_instr.imm[7]}}, w_instr.imm};
        end else if (N == 8) begin : g_imm_same
            assign w_imm_ext = w_instr.imm;
        end else begin : g_imm_trunc
            assign w_imm_ext = w_instr.imm[N-1:0];
        end
    endgenerate

    always_comb begin
        case (w_instr.src)
            c_src_imm: w_src_val = w_imm_ext;
            c_src_acc: w_src_val = r_acc;
            c_src_in:  w_src_val = lnk.in_data;
            default:   w_src_val = '0;
        endcase
    end

    assign w_uses_in    = reads_src(w_instr.op) && (w_instr.src == c_src_in);
    assign w_in_blocked = w_uses_in && !lnk.in_valid;
    assign w_out_accept = r_out_valid && lnk.out_ready;

    always_comb begin
        case (w_instr.op)
            c_op_jmp: w_take_jump = 1'b1;
            c_op_jez: w_take_jump = (r_acc == '0);
            c_op_jnz: w_take_jump = (r_acc != '0);
            c_op_jgz: w_take_jump = (r_acc != '0) && !r_acc[N-1];
            c_op_jlz: w_take_jump = r_acc[N-1];
            default:  w_take_jump = 1'b0;
        endcase
    end

    tis_node_sequencer_alu #(.N(N)) u_alu (
        .i_code (alu_code(w_instr.op)),
        .i_a    (r_acc),
        .i_b    (w_src_val),
        .o_res  (w_alu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (run) w_state_nxt = c_st_run;
            end
            c_st_run: begin
                if (!run) begin
                    w_state_nxt = c_st_idle;
                end else if (w_instr.op == c_op_mov_out && !w_in_blocked) begin
                    w_state_nxt = c_st_wait_out;
                end
            end
            c_st_wait_out: begin
                // run is only sampled once the pending output has been taken
                if (w_out_accept) w_state_nxt = run ? c_st_run : c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_exec     = 1'b0;
        w_in_ready = 1'b0;
        w_stalled  = 1'b0;
        case (r_state)
            c_st_run: begin
                w_stalled  = w_in_blocked;
                w_in_ready = run && w_uses_in;
                w_exec     = run && !w_in_blocked;
            end
            c_st_wait_out: w_stalled = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_acc       <= '0;
            r_bak       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_exec) begin
            // MOV->OUT holds the PC until the output handshake retires it
            if (w_instr.op != c_op_mov_out) begin
                r_pc <= w_take_jump ? w_instr.imm[AW-1:0] : r_pc + c_pc_one;
            end
            case (w_instr.op)
                c_op_mov_acc: r_acc <= w_src_val;
                c_op_mov_out: begin
                    r_out_data  <= w_src_val;
                    r_out_valid <= 1'b1;
                end
                c_op_add, c_op_sub, c_op_neg: r_acc <= w_alu_res;
                c_op_swp: begin
                    r_acc <= r_bak;
                    r_bak <= r_acc;
                end
                c_op_sav: r_bak <= r_acc;
                default: ;
            endcase
        end else if (r_state == c_st_wait_out && w_out_accept) begin
            r_out_valid <= 1'b0;
            r_pc        <= r_pc + c_pc_one;
        end
    end

    assign lnk.in_ready  = w_in_ready;
    assign lnk.out_data  = r_out_data;
    assign lnk.out_valid = r_out_valid;
    assign acc_o         = r_acc;
    assign pc_o          = r_pc;
    assign stalled       = w_stalled;

endmodule

`default_nettype wire
